// File: rtl/ship_pkg.sv
// Shared ship geometry, ROM sizing, colour constants and the VGA bus bundle
// used by the ship overlay drawer.
package ship_pkg;

  localparam int SHIP_W      = 48;
  localparam int SHIP_H      = 24;
  localparam int SHIP_ID_MAX = 20;
  localparam int ROM_ADDR_W  = 9;

  localparam logic [11:0] RGB_WHITE = 12'hF_F_F;
  localparam logic [11:0] RGB_RED   = 12'hF_0_0;

  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_bus_t;

endpackage

// File: rtl/ship_draw_delay.sv
// Fixed-length register chain with asynchronous active-low clear, used to keep
// the VGA timing/colour bus aligned with the ship pipeline.
module delay #(
  parameter int WIDTH   = 38,
  parameter int CLK_DEL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [CLK_DEL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[CLK_DEL-1];

endmodule

// File: rtl/ship_draw.sv
// Overlays one ROM-sourced ship bitmap onto the VGA stream with a 3-cycle pipeline.
// Hit flashing is built only when the macro SHIP_HIT_FLASH_EN is defined.
module ship_draw
  import ship_pkg::*;
#(
  parameter logic [11:0] SHIP_COLOR   = RGB_WHITE,
  parameter logic [11:0] HIT_COLOR    = RGB_RED,
  parameter int          FLASH_FRAMES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [10:0]           vcount_in,
  input  logic [10:0]           hcount_in,
  input  logic                  vsync_in,
  input  logic                  hsync_in,
  input  logic                  vblnk_in,
  input  logic                  hblnk_in,
  input  logic [11:0]           rgb_in,
  input  logic [11:0]           xpos,
  input  logic [11:0]           ypos,
  input  logic [4:0]            ship_id,
  input  logic                  hit,
  output logic [ROM_ADDR_W-1:0] ship_addr,
  input  logic [47:0]           ship_line_pixels,
  output logic [10:0]           vcount_out,
  output logic [10:0]           hcount_out,
  output logic                  vsync_out,
  output logic                  hsync_out,
  output logic                  vblnk_out,
  output logic                  hblnk_out,
  output logic [11:0]           rgb_out
);

  vga_bus_t    bus_in, bus_d2;
  logic        vblnk_q, armed, frame_start;
  logic [11:0] x_lat, y_lat;
  logic [4:0]  id_lat;
  logic        in_area, in_area_d1, in_area_d2;
  logic [4:0]  row;
  logic [5:0]  col, col_d1, col_d2;
  logic        pix;
  logic [11:0] colour;

  assign frame_start = vblnk_in & ~vblnk_q;

  // armed stays low after reset so nothing is drawn until a full frame latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q <= 1'b0;
      armed   <= 1'b0;
      x_lat   <= '0;
      y_lat   <= '0;
      id_lat  <= '0;
    end else begin
      vblnk_q <= vblnk_in;
      if (frame_start) begin
        armed  <= 1'b1;
        x_lat  <= xpos;
        y_lat  <= ypos;
        id_lat <= ship_id;
      end
    end
  end

  always_comb begin
    in_area = armed & ~hblnk_in & ~vblnk_in & (id_lat <= 5'(SHIP_ID_MAX))
            & ({1'b0, hcount_in} >= x_lat)
            & ({2'b00, hcount_in} < ({1'b0, x_lat} + 13'(SHIP_W)))
            & ({1'b0, vcount_in} >= y_lat)
            & ({2'b00, vcount_in} < ({1'b0, y_lat} + 13'(SHIP_H)));
    row = 5'({1'b0, vcount_in} - y_lat);
    col = 6'({1'b0, hcount_in} - x_lat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ship_addr  <= '0;
      col_d1     <= '0;
      col_d2     <= '0;
      in_area_d1 <= 1'b0;
      in_area_d2 <= 1'b0;
    end else begin
      ship_addr  <= in_area ? ROM_ADDR_W'(id_lat) * ROM_ADDR_W'(SHIP_H)
                              + ROM_ADDR_W'(row) + ROM_ADDR_W'(1) : '0;
      col_d1     <= col;
      in_area_d1 <= in_area;
      col_d2     <= col_d1;
      in_area_d2 <= in_area_d1;
    end
  end

  assign bus_in = '{vcount: vcount_in, hcount: hcount_in, vsync: vsync_in,
                    hsync: hsync_in, vblnk: vblnk_in, hblnk: hblnk_in, rgb: rgb_in};

  // Two stages here plus the output register below give the 3-cycle alignment
  delay #(.WIDTH($bits(vga_bus_t)), .CLK_DEL(2)) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus_in),
    .dout (bus_d2)
  );

  assign pix = (col_d2 < 6'(SHIP_W)) ? ship_line_pixels[6'(SHIP_W - 1) - col_d2] : 1'b0;

`ifdef SHIP_HIT_FLASH_EN
  logic        hit_lat;
  logic        flash_on;
  logic [15:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_lat   <= 1'b0;
      flash_on  <= 1'b0;
      frame_cnt <= '0;
    end else if (frame_start) begin
      hit_lat <= hit;
      if (frame_cnt == 16'(FLASH_FRAMES - 1)) begin
        frame_cnt <= '0;
        flash_on  <= ~flash_on;
      end else begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign colour = (hit_lat & flash_on) ? HIT_COLOR : SHIP_COLOR;
`else
  logic [11:0] unused_cfg;
  assign unused_cfg = HIT_COLOR ^ 12'(FLASH_FRAMES) ^ {11'd0, hit};
  assign colour     = SHIP_COLOR;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcount_out <= '0;
      hcount_out <= '0;
      vsync_out  <= 1'b0;
      hsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      vcount_out <= bus_d2.vcount;
      hcount_out <= bus_d2.hcount;
      vsync_out  <= bus_d2.vsync;
      hsync_out  <= bus_d2.hsync;
      vblnk_out  <= bus_d2.vblnk;
      hblnk_out  <= bus_d2.hblnk;
      rgb_out    <= (in_area_d2 & pix) ? colour : bus_d2.rgb;
    end
  end

endmodule

// File: tb/tb_ship_draw.sv
// Directed bench for ship_draw: a small registered ROM stand-in feeds the DUT and
// hand-computed addresses and pixels are checked with immediate assertions.
module tb_ship_draw;

  localparam logic [11:0] W = 12'hFFF;
  localparam logic [11:0] P = 12'h0A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] vcount_in, hcount_in;
  logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic [4:0]  ship_id;
  logic        hit;
  logic [8:0]  ship_addr;
  logic [47:0] ship_line_pixels;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_out;

  int nAsserts = 0;
  int nFail    = 0;

  typedef struct {
    logic [37:0] tim;
    logic [11:0] rgb;
  } exp_t;
  exp_t expQ[$];

  ship_draw dut (
    .clk(clk), .rst_n(rst_n),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .ship_id(ship_id), .hit(hit),
    .ship_addr(ship_addr), .ship_line_pixels(ship_line_pixels),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Line 0 is all ones so that a leak of the idle address would show up as colour
  function automatic logic [47:0] romLine(input logic [8:0] a);
    case (a)
      9'd0:    romLine = '1;
      9'd4:    romLine = 48'h1E00_0000_0001;
      9'd24:   romLine = 48'h8000_0000_0000;
      9'd25:   romLine = '0;
      default: romLine = 48'h5555_5555_5555;
    endcase
  endfunction

  always @(posedge clk) ship_line_pixels <= romLine(ship_addr);

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    nAsserts++;
    assert (obs === expv)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input int h, input int v, input logic hb, input logic vb,
                               input logic [11:0] rgb, input int expAddr,
                               input logic [11:0] expRgb);
    exp_t e;
    @(negedge clk);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = hcount_in[1];
    vsync_in  = vcount_in[0];
    rgb_in    = rgb;
    e.tim = {vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in};
    e.rgb = expRgb;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput($sformatf("ship_addr h=%0d v=%0d", h, v), 48'(ship_addr), 48'(expAddr));
    if (expQ.size() == 3) begin
      e = expQ.pop_front();
      checkOutput("timing_out",
                  48'({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out}),
                  48'(e.tim));
      checkOutput("rgb_out", 48'(rgb_out), 48'(e.rgb));
    end
  endtask

  task automatic frameEdge();
    for (int i = 0; i < 3; i++) applyStimulus(0, 600, 1'b1, 1'b1, P, 0, P);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, 48'({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out,
                          rgb_out, ship_addr}), 48'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    hcount_in = 11'd103; vcount_in = 11'd53; hsync_in = 1'b1; vsync_in = 1'b1;
    hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = P;
    xpos = 12'd100; ypos = 12'd50; ship_id = 5'd0; hit = 1'b0;
    #12;
    checkAllZero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;

    // Not yet latched: no drawing before the first vblnk rising edge
    applyStimulus(103, 53, 1'b0, 1'b0, P, 0, P);
    applyStimulus(104, 53, 1'b0, 1'b0, P, 0, P);
    frameEdge();

    for (int h = 98; h <= 110; h++)
      applyStimulus(h, 53, 1'b0, 1'b0, P, (h >= 100) ? 4 : 0,
                    (h >= 103 && h <= 106) ? W : P);
    applyStimulus(146, 53, 1'b0, 1'b0, P, 4, P);
    applyStimulus(147, 53, 1'b0, 1'b0, P, 4, W);
    applyStimulus(148, 53, 1'b0, 1'b0, P, 0, P);
    applyStimulus(100, 73, 1'b0, 1'b0, P, 24, W);
    applyStimulus(101, 73, 1'b0, 1'b0, P, 24, P);
    applyStimulus(100, 74, 1'b0, 1'b0, P, 0, P);
    applyStimulus(100, 49, 1'b0, 1'b0, P, 0, P);
    applyStimulus(103, 53, 1'b1, 1'b0, P, 0, P);

    // Moving mid-frame has no effect until the next frame latch
    xpos = 12'd300;
    applyStimulus(103, 53, 1'b0, 1'b0, P, 4, W);
    applyStimulus(303, 53, 1'b0, 1'b0, P, 0, P);
    frameEdge();
    applyStimulus(303, 53, 1'b0, 1'b0, P, 4, W);
    applyStimulus(103, 53, 1'b0, 1'b0, P, 0, P);
    applyStimulus(302, 53, 1'b0, 1'b0, P, 4, P);

    // id 1 first line is blank in the ROM
    xpos = 12'd100; ship_id = 5'd1;
    frameEdge();
    for (int h = 100; h <= 103; h++) applyStimulus(h, 50, 1'b0, 1'b0, P, 25, P);

    // Out-of-range id is never drawn
    ship_id = 5'd21; hit = 1'b1;
    frameEdge();
    applyStimulus(103, 53, 1'b0, 1'b0, P, 0, P);
    applyStimulus(100, 50, 1'b0, 1'b0, P, 0, P);

    // Ship clipped by the screen edge
    xpos = 12'd1010; ypos = 12'd760; ship_id = 5'd0;
    frameEdge();
    applyStimulus(1013, 763, 1'b0, 1'b0, P, 4, W);
    applyStimulus(1012, 763, 1'b0, 1'b0, P, 4, P);
    applyStimulus(1057, 763, 1'b0, 1'b0, P, 4, W);
    applyStimulus(1058, 763, 1'b0, 1'b0, P, 0, P);
    applyStimulus(1010, 783, 1'b0, 1'b0, P, 24, W);
    applyStimulus(1010, 784, 1'b0, 1'b0, P, 0, P);
    applyStimulus(1013, 763, 1'b1, 1'b0, P, 0, P);

    // Reset mid-line, then the ship must stay hidden until the next frame latch
    xpos = 12'd100; ypos = 12'd50;
    frameEdge();
    applyStimulus(103, 53, 1'b0, 1'b0, P, 4, W);
    applyStimulus(104, 53, 1'b0, 1'b0, P, 4, W);
    applyStimulus(105, 53, 1'b0, 1'b0, P, 4, W);
    #1 rst_n = 1'b0;
    #1 checkAllZero("midline_reset_outputs");
    expQ.delete();
    #1 rst_n = 1'b1;
    applyStimulus(103, 53, 1'b0, 1'b0, P, 0, P);
    applyStimulus(104, 53, 1'b0, 1'b0, P, 0, P);
    applyStimulus(105, 53, 1'b0, 1'b0, P, 0, P);
    frameEdge();
    applyStimulus(103, 53, 1'b0, 1'b0, P, 4, W);
    applyStimulus(107, 53, 1'b0, 1'b0, P, 4, P);
    applyStimulus(0, 600, 1'b1, 1'b1, P, 0, P);
    applyStimulus(0, 600, 1'b1, 1'b1, P, 0, P);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
